// File: rtl/mem_io_access_seq_if.sv
// CPU-side strobes, BRAM port and memory-mapped IO bus of mem_io_access_seq.
// master = sequencer side, slave = decoder/RAM/IO side.
// io_req is held by the master until the slave returns a one-cycle io_ack.
interface mem_io_access_seq_if;
  logic        mem_read;
  logic        mem_write;
  logic        io_read;
  logic        io_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ram_en;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        io_req;
  logic        io_we;
  logic [9:0]  io_addr;
  logic [31:0] io_wdata;
  logic        io_ack;
  logic [31:0] io_rdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        stall;
  logic        io_err;

  modport master (
    input  mem_read, mem_write, io_read, io_write, addr, wdata,
    input  ram_rdata, io_ack, io_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    output io_req, io_we, io_addr, io_wdata,
    output rdata, rdata_valid, stall, io_err
  );

  modport slave (
    output mem_read, mem_write, io_read, io_write, addr, wdata,
    output ram_rdata, io_ack, io_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    input  io_req, io_we, io_addr, io_wdata,
    input  rdata, rdata_valid, stall, io_err
  );
endinterface

// File: rtl/mem_io_access_seq.sv
// Sequences decoded RAM/IO load-store strobes onto BRAM and IO bus; IO_TIMEOUT_EN adds an IO watchdog.
// Latency: stores 0 stall cycles, RAM loads RAM_LATENCY+1, IO accesses 1 + cycles until io_ack.
// Backpressure: stall holds PC/regfile while a load or IO access is in flight; io_req held until io_ack.
module mem_io_access_seq #(
  parameter int RAM_LATENCY = 1,
  parameter int IO_TIMEOUT  = 255
) (
  input logic                 clk,
  input logic                 rst_n,
  mem_io_access_seq_if.master bus
);

  typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_WAIT, DONE} state_t;

  state_t      state;
  logic [2:0]  lat_cnt;
  logic [9:0]  io_addr_q;
  logic [31:0] io_wdata_q;
  logic        io_we_q;
  logic        io_rd_q;
  logic [31:0] rdata_q;
  logic        rdata_valid_q;

  logic in_idle;
  logic sel_io_rd;
  logic sel_io_wr;
  logic sel_io;
  logic sel_ram_rd;
  logic sel_ram_wr;

  // Fixed priority: io_read > io_write > mem_read > mem_write.
  assign in_idle    = (state == IDLE);
  assign sel_io_rd  = in_idle & bus.io_read;
  assign sel_io_wr  = in_idle & ~bus.io_read & bus.io_write;
  assign sel_io     = sel_io_rd | sel_io_wr;
  assign sel_ram_rd = in_idle & ~bus.io_read & ~bus.io_write & bus.mem_read;
  assign sel_ram_wr = in_idle & ~bus.io_read & ~bus.io_write & ~bus.mem_read & bus.mem_write;

  // Issue-cycle outputs are combinational from the strobes; gating with rst_n
  // keeps them low during reset even if the decoder still holds a strobe.
  logic out_io;
  logic out_ram_rd;
  logic out_ram_wr;

  assign out_io     = rst_n & sel_io;
  assign out_ram_rd = rst_n & sel_ram_rd;
  assign out_ram_wr = rst_n & sel_ram_wr;

  assign bus.ram_en    = out_ram_rd | out_ram_wr;
  assign bus.ram_we    = out_ram_wr;
  assign bus.ram_addr  = (out_ram_rd | out_ram_wr) ? bus.addr[15:2] : 14'd0;
  assign bus.ram_wdata = out_ram_wr ? bus.wdata : 32'd0;

  assign bus.io_req   = out_io | (state == IO_WAIT);
  assign bus.io_we    = out_io ? (rst_n & sel_io_wr) : ((state == IO_WAIT) & io_we_q);
  assign bus.io_addr  = out_io ? bus.addr[9:0] : io_addr_q;
  assign bus.io_wdata = out_io ? bus.wdata : io_wdata_q;

  assign bus.stall       = out_ram_rd | out_io | (state == RAM_WAIT) | (state == IO_WAIT);
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;

`ifdef IO_TIMEOUT_EN
  localparam int TW = $clog2(IO_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(IO_TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;
  logic          io_err_q;

  assign bus.io_err = io_err_q;
`else
  logic [31:0] unused_io_timeout;

  assign unused_io_timeout = 32'(IO_TIMEOUT);
  assign bus.io_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lat_cnt       <= 3'd0;
      io_addr_q     <= 10'd0;
      io_wdata_q    <= 32'd0;
      io_we_q       <= 1'b0;
      io_rd_q       <= 1'b0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
`ifdef IO_TIMEOUT_EN
      tmo_cnt       <= '0;
      io_err_q      <= 1'b0;
`endif
    end else begin
      rdata_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_io) begin
            io_addr_q  <= bus.addr[9:0];
            io_wdata_q <= bus.wdata;
            io_we_q    <= sel_io_wr;
            io_rd_q    <= sel_io_rd;
`ifdef IO_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
            // An ack arriving in the issue cycle completes the access at once.
            if (bus.io_ack) begin
              if (sel_io_rd) rdata_q <= bus.io_rdata;
              rdata_valid_q <= sel_io_rd;
              state         <= DONE;
            end else begin
              state <= IO_WAIT;
            end
          end else if (sel_ram_rd) begin
            lat_cnt <= 3'(RAM_LATENCY - 1);
            state   <= RAM_WAIT;
          end
        end

        RAM_WAIT: begin
          if (lat_cnt == 3'd0) begin
            rdata_q       <= bus.ram_rdata;
            rdata_valid_q <= 1'b1;
            state         <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        IO_WAIT: begin
          if (bus.io_ack) begin
            if (io_rd_q) rdata_q <= bus.io_rdata;
            rdata_valid_q <= io_rd_q;
            state         <= DONE;
          end
`ifdef IO_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            io_err_q      <= 1'b1;
            rdata_q       <= 32'd0;
            rdata_valid_q <= io_rd_q;
            state         <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        // The PC advances at the end of DONE, so any strobe still high here is stale.
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_access_seq.sv
// Directed bench for mem_io_access_seq: stimulus pushes expected load data, a monitor checks rdata_valid pulses.
// RAM is a small latency-RL stub; the IO target is driven directly by the stimulus.
module tb_mem_io_access_seq;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_io_access_seq_if bus();

  mem_io_access_seq #(.RAM_LATENCY(RL), .IO_TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] sb_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM stub: read data appears RL cycles after ram_en, garbage otherwise.
  logic [31:0] mem [0:255];
  logic [31:0] pipe [0:RL-1];
  always @(posedge clk) begin
    if (bus.ram_en && bus.ram_we) mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
    pipe[0] <= (bus.ram_en && !bus.ram_we) ? mem[bus.ram_addr[7:0]] : 32'hBAD0_BAD0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.ram_rdata = pipe[RL-1];

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.rdata_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: rdata_valid with rdata 0x%08h, none expected at %0t", bus.rdata, $time);
      end else begin
        sb_exp = sb.pop_front();
        chk("sb_rdata", bus.rdata, sb_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive stall cycles; returns at the negedge of the first non-stall cycle.
  task automatic count_stall(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!done) begin
        @(negedge clk);
        if (bus.stall) begin
          n++;
          @(posedge clk);
        end else begin
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic ram_store(input logic [31:0] a, input logic [31:0] d, input logic [13:0] wa);
    bus.mem_write = 1'b1;
    bus.addr      = a;
    bus.wdata     = d;
    #2;
    chk("st_ram_en", bus.ram_en, 1);
    chk("st_ram_we", bus.ram_we, 1);
    chk("st_ram_addr", bus.ram_addr, wa);
    chk("st_ram_wdata", bus.ram_wdata, d);
    chk("st_stall", bus.stall, 0);
    chk("st_io_req", bus.io_req, 0);
    tick();
    bus.mem_write = 1'b0;
    tick();
  endtask

  task automatic ram_load(input logic [31:0] a, input logic [31:0] e, input logic [13:0] wa,
                          input logic also_wr);
    int n;
    bus.mem_read  = 1'b1;
    bus.mem_write = also_wr;
    bus.addr      = a;
    bus.wdata     = 32'hCAFE_0000;
    sb.push_back(e);
    #2;
    chk("ld_ram_en", bus.ram_en, 1);
    chk("ld_ram_we", bus.ram_we, 0);
    chk("ld_ram_addr", bus.ram_addr, wa);
    count_stall(n);
    chk("ld_stall_cycles", n, 3);
    chk("ld_done_no_reissue", bus.ram_en, 0);
    tick();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    #2;
    chk("ld_idle_stall", bus.stall, 0);
    tick();
  endtask

  initial begin
    int n;
    int nreq;
    bus.mem_read = 1'b1;
    bus.mem_write = 1'b0;
    bus.io_read = 1'b0;
    bus.io_write = 1'b0;
    bus.addr = 32'h0000_0010;
    bus.wdata = 32'h0;
    bus.io_ack = 1'b0;
    bus.io_rdata = 32'h0;

    // Reset: everything low even with a strobe asserted.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_io_req", bus.io_req, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rdata_valid", bus.rdata_valid, 0);
    chk("rst_io_err", bus.io_err, 0);
    bus.mem_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    ram_store(32'h0000_0040, 32'hDEAD_BEEF, 14'h010);
    ram_store(32'h0000_0010, 32'h1234_5678, 14'h004);
    ram_load(32'h0000_0010, 32'h1234_5678, 14'h004, 1'b0);
    ram_load(32'h0000_0040, 32'hDEAD_BEEF, 14'h010, 1'b1);
    ram_load(32'h0000_0040, 32'hDEAD_BEEF, 14'h010, 1'b0);

    // IO load, ack in the fifth io_req cycle; address changes mid-wait.
    bus.io_read = 1'b1;
    bus.addr = 32'hFFFF_FC70;
    sb.push_back(32'h0000_0055);
    #2;
    chk("io_rd_addr", bus.io_addr, 10'h070);
    chk("io_rd_we", bus.io_we, 0);
    chk("io_rd_stall", bus.stall, 1);
    nreq = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) bus.addr = 32'h0000_0000;
      if (c == 5) begin bus.io_ack = 1'b1; bus.io_rdata = 32'h0000_0055; end
      if (c == 6) begin bus.io_ack = 1'b0; bus.io_rdata = 32'h0; bus.io_read = 1'b0; end
      @(negedge clk);
      if (bus.io_req) nreq++;
      if (c == 3) chk("io_addr_held", bus.io_addr, 10'h070);
      if (c == 6) chk("io_done_stall", bus.stall, 0);
      tick();
    end
    chk("io_req_cycles", nreq, 5);

    // IO store overlapping a RAM store: IO wins.
    bus.io_write = 1'b1;
    bus.mem_write = 1'b1;
    bus.addr = 32'hFFFF_FC04;
    bus.wdata = 32'h0000_00A5;
    #2;
    chk("iow_req", bus.io_req, 1);
    chk("iow_we", bus.io_we, 1);
    chk("iow_wdata", bus.io_wdata, 32'hA5);
    chk("iow_ram_we", bus.ram_we, 0);
    chk("iow_ram_en", bus.ram_en, 0);
    tick();
    bus.wdata = 32'h0;
    bus.io_ack = 1'b1;
    #2;
    chk("iow_wdata_held", bus.io_wdata, 32'hA5);
    chk("iow_ram_we_wait", bus.ram_we, 0);
    tick();
    bus.io_ack = 1'b0;
    bus.io_write = 1'b0;
    bus.mem_write = 1'b0;
    #2;
    chk("iow_done_req", bus.io_req, 0);
    chk("iow_rdata_kept", bus.rdata, 32'h55);
    tick();

    // IO read acked in its issue cycle.
    bus.io_read = 1'b1;
    bus.addr = 32'hFFFF_FC08;
    bus.io_ack = 1'b1;
    bus.io_rdata = 32'h0BAD_F00D;
    sb.push_back(32'h0BAD_F00D);
    #2;
    chk("ioe_req", bus.io_req, 1);
    tick();
    bus.io_ack = 1'b0;
    bus.io_read = 1'b0;
    #2;
    chk("ioe_done_stall", bus.stall, 0);
    chk("ioe_done_req", bus.io_req, 0);
    tick();

    // Stray ack with no request pending.
    bus.io_ack = 1'b1;
    bus.io_rdata = 32'hFFFF_FFFF;
    #2;
    chk("stray_stall", bus.stall, 0);
    tick();
    bus.io_ack = 1'b0;
    #2;
    chk("stray_rdata", bus.rdata, 32'h0BAD_F00D);
    tick();

`ifdef IO_TIMEOUT_EN
    bus.io_read = 1'b1;
    bus.addr = 32'hFFFF_FC20;
    sb.push_back(32'h0);
    count_stall(n);
    chk("tmo_stall_cycles", n, 9);
    chk("tmo_err", bus.io_err, 1);
    tick();
    bus.io_read = 1'b0;
    repeat (2) tick();
    #2;
    chk("tmo_err_sticky", bus.io_err, 1);
    tick();
`endif

    // Asynchronous reset in the middle of an IO wait.
    bus.io_read = 1'b1;
    bus.addr = 32'hFFFF_FC10;
    repeat (3) tick();
    @(negedge clk);
    chk("rio_req_before", bus.io_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rio_req", bus.io_req, 0);
    chk("rio_stall", bus.stall, 0);
    chk("rio_err", bus.io_err, 0);
    tick();
    bus.io_read = 1'b0;
    rst_n = 1'b1;
    #2;
    chk("rio_idle_req", bus.io_req, 0);
    tick();
    bus.mem_write = 1'b1;
    bus.addr = 32'h0000_0044;
    bus.wdata = 32'h0000_1111;
    #2;
    chk("rio_idle_ram_en", bus.ram_en, 1);
    chk("rio_idle_stall", bus.stall, 0);
    tick();
    bus.mem_write = 1'b0;
    repeat (3) tick();

    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
